// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte sources.
// Ports: i_Clock/i_Reset, requester valid/byte/ready, uart_tx DV/byte/active/done, status.
module uart_tx_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [2:0]           o_Grant_Id
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_ISSUE,
    HDR_WAIT,
    DATA_ISSUE,
    DATA_WAIT
  } state_t;

  state_t               state, state_n;
  logic [2:0]           last, last_n;
  logic [7:0]           data_reg, data_n;
  logic                 dv_n;
  logic [7:0]           byte_n;
  logic [NUM_REQ-1:0]   ready_n;
  logic [2:0]           grant_n;

  logic [2:0]           sel;
  logic [7:0]           sel_byte;
  logic                 hi_found;
  logic [2:0]           hi_idx, lo_idx;
  logic [7:0]           hi_byte, lo_byte;

  // Lowest valid index above last wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_byte  = '0;
    lo_byte  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_Req_Valid[i]) begin
        lo_idx  = 3'(i);
        lo_byte = i_Req_Byte[8*i +: 8];
        if (3'(i) > last) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
          hi_byte  = i_Req_Byte[8*i +: 8];
        end
      end
    end
    sel      = hi_found ? hi_idx : lo_idx;
    sel_byte = hi_found ? hi_byte : lo_byte;
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    data_n  = data_reg;
    dv_n    = 1'b0;
    byte_n  = o_Tx_Byte;
    ready_n = '0;
    grant_n = o_Grant_Id;
    unique case (state)
      IDLE: begin
        if ((|i_Req_Valid) && !i_Tx_Active) begin
          last_n  = sel;
          grant_n = sel;
          data_n  = sel_byte;
          for (int i = 0; i < NUM_REQ; i++) begin
            ready_n[i] = (sel == 3'(i));
          end
          state_n = HEADER_EN ? HDR_ISSUE : DATA_ISSUE;
        end
      end
      HDR_ISSUE: begin
        if (!i_Tx_Active) begin
          dv_n    = 1'b1;
          byte_n  = HEADER_BASE | {5'b0, o_Grant_Id};
          state_n = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        if (i_Tx_Done) state_n = DATA_ISSUE;
      end
      DATA_ISSUE: begin
        if (!i_Tx_Active) begin
          dv_n    = 1'b1;
          byte_n  = data_reg;
          state_n = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (i_Tx_Done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // last resets to the top index so the first grant lands on index 0.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      last        <= 3'(NUM_REQ - 1);
      data_reg    <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
      o_Req_Ready <= '0;
      o_Grant_Id  <= '0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      data_reg    <= data_n;
      o_Tx_DV     <= dv_n;
      o_Tx_Byte   <= byte_n;
      o_Req_Ready <= ready_n;
      o_Grant_Id  <= grant_n;
    end
  end

  assign o_Busy = (state != IDLE);

endmodule
